// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the cache-fill arbiter: FSM states, fill owner, line alignment.
// Also records the memory read latency that the fill timing is built around.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [15:0] LINE_MASK = 16'hFFF0;
    localparam int          MEM_LAT   = 4;

endpackage

// File: rtl/fill_counter.sv
// Line-word counter: clears to 0, increments on inc, saturates at LAST (flagged by last).
// Single cycle update; inc is ignored once last is reached.
module fill_counter #(
    parameter int WORDS = 8,
    parameter int LAST  = WORDS,
    localparam int CW   = $clog2(WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(LAST));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I/D line fills and D write-throughs onto one pipelined memory (dc_wr > dc_miss > ic_miss).
// Fill = WORDS + memory latency cycles from grant; requests simply wait while the FSM is busy.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_miss_addr,
    output logic              ic_fill_valid,
    output logic [2:0]        ic_fill_word,
    output logic [DATA_W-1:0] ic_fill_data,
    output logic              ic_fill_done,
    input  logic              dc_miss,
    input  logic [ADDR_W-1:0] dc_miss_addr,
    output logic              dc_fill_valid,
    output logic [2:0]        dc_fill_word,
    output logic [DATA_W-1:0] dc_fill_data,
    output logic              dc_fill_done,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              busy
);

    localparam int CW             = $clog2(WORDS + 1);
    localparam int BYTES_PER_WORD = DATA_W / 8;

    arbState_t         state, stateNext;
    owner_t            owner;
    logic [ADDR_W-1:0] baseAddr, wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [CW-1:0]     issueCnt, recvCnt;
    logic              issueDone, recvLast;
    logic              idle, issuing, rxFire;

    assign idle    = (state == IDLE);
    assign busy    = !idle;
    assign issuing = (state == FILL) && !issueDone;
    // Only accept a returned word if a read for it is actually outstanding.
    assign rxFire  = (state == FILL) && mem_data_valid && (issueCnt > recvCnt);

    fill_counter #(.WORDS(WORDS), .LAST(WORDS)) issueCtr (
        .clk   (clk),
        .rst   (rst),
        .clear (idle),
        .inc   (issuing),
        .cnt   (issueCnt),
        .last  (issueDone)
    );

    fill_counter #(.WORDS(WORDS), .LAST(WORDS - 1)) recvCtr (
        .clk   (clk),
        .rst   (rst),
        .clear (idle),
        .inc   (rxFire),
        .cnt   (recvCnt),
        .last  (recvLast)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_I;
            baseAddr <= '0;
            wrAddr   <= '0;
            wrData   <= '0;
        end else begin
            state <= stateNext;
            if (idle) begin
                if (dc_wr_req) begin
                    wrAddr <= dc_wr_addr;
                    wrData <= dc_wr_data;
                end else if (dc_miss) begin
                    owner    <= OWN_D;
                    baseAddr <= dc_miss_addr & LINE_MASK;
                end else if (ic_miss) begin
                    owner    <= OWN_I;
                    baseAddr <= ic_miss_addr & LINE_MASK;
                end
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (dc_wr_req) begin
                    stateNext = WRITE;
                end else if (dc_miss || ic_miss) begin
                    stateNext = FILL;
                end
            end
            WRITE:   stateNext = IDLE;
            FILL:    if (rxFire && recvLast) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_data_in   = '0;
        dc_wr_ack     = 1'b0;
        ic_fill_valid = 1'b0;
        ic_fill_word  = '0;
        ic_fill_data  = '0;
        ic_fill_done  = 1'b0;
        dc_fill_valid = 1'b0;
        dc_fill_word  = '0;
        dc_fill_data  = '0;
        dc_fill_done  = 1'b0;

        if (state == WRITE) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = wrAddr;
            mem_data_in = wrData;
            dc_wr_ack   = 1'b1;
        end

        if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = baseAddr + ADDR_W'(issueCnt) * ADDR_W'(BYTES_PER_WORD);
        end

        // Returned words go straight through, unregistered, to the owning cache.
        if (rxFire) begin
            if (owner == OWN_D) begin
                dc_fill_valid = 1'b1;
                dc_fill_word  = recvCnt[2:0];
                dc_fill_data  = mem_data_out;
                dc_fill_done  = recvLast;
            end else begin
                ic_fill_valid = 1'b1;
                ic_fill_word  = recvCnt[2:0];
                ic_fill_data  = mem_data_out;
                ic_fill_done  = recvLast;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the cache miss/fill interface: accepts line-fill requests from the I-cache and the D-cache, plus D-cache write-through requests.
- Serialises all of them onto the single pipelined main memory.
- Streams returned words back to the requesting cache, tagged with the word index, and ends each fill with a done pulse.
- Sits between cpu's InstCache/DataCache and the multicycle memory model.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width
WORDS, 8, words per cache line (16-byte line)
MEM_LAT, 4, memory read latency in cycles from mem_en to mem_data_valid

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ic_miss  in  1  I-cache fill request, held high until ic_fill_done
ic_miss_addr  in  ADDR_W  I-cache miss byte address
ic_fill_valid  out  1  ic_fill_data holds a valid word this cycle
ic_fill_word  out  3  index of the returned word within the line
ic_fill_data  out  DATA_W  returned word
ic_fill_done  out  1  one-cycle pulse, coincident with the last word
dc_miss  in  1  D-cache fill request, held until dc_fill_done
dc_miss_addr  in  ADDR_W  D-cache miss byte address
dc_fill_valid, dc_fill_word, dc_fill_data, dc_fill_done  out  1/3/DATA_W/1  same meaning as the ic_ equivalents
dc_wr_req  in  1  write-through request, held until dc_wr_ack
dc_wr_addr  in  ADDR_W  write byte address
dc_wr_data  in  DATA_W  write data
dc_wr_ack  out  1  one-cycle pulse when the write is issued to memory
mem_en  out  1  memory access enable
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory byte address
mem_data_in  out  DATA_W  write data to memory
mem_data_out  in  DATA_W  read data from memory
mem_data_valid  in  1  mem_data_out valid (MEM_LAT cycles after a read issue)
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, issue_cnt and recv_cnt go to 0. A synchronous rst mid-fill aborts the fill. mem_data_valid arriving after the abort is ignored.
- FSM states: IDLE, WRITE, FILL (issuing and draining), DONE.
- Grant in IDLE uses fixed priority dc_wr_req > dc_miss > ic_miss, evaluated every IDLE cycle.
  - On a grant, the FSM latches the requester (owner) and the line base (addr & ~0xF) or the write address/data.
  - Unserved requests keep waiting while held.
- WRITE, one cycle: mem_en=1, mem_wr=1, mem_addr and mem_data_in come from the latches; dc_wr_ack=1. The FSM then returns to IDLE.
- FILL issue: for issue_cnt 0..WORDS-1, one read per cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt. mem_en drops once all WORDS reads are issued.
- FILL receive: each mem_data_valid does the following in the same cycle, with no register stage:
  - drives the owner's fill_valid=1, fill_word=recv_cnt, fill_data=mem_data_out;
  - increments recv_cnt.
  - On recv_cnt==WORDS-1, fill_done=1 in that same cycle and the FSM goes to DONE.
- Fill latency: first word arrives MEM_LAT cycles after the first issue. The whole fill takes WORDS+MEM_LAT cycles from grant (12 with defaults).
- DONE, one cycle: lets the requester drop its miss. The FSM then returns to IDLE, and the next grant can come in the following cycle.
- The non-owner cache's fill outputs stay 0 throughout.
- mem_data_valid outside FILL is ignored. No more than WORDS words are ever forwarded per fill.
- Requester drops its miss mid-fill: the fill still completes and done still pulses.
- Address arithmetic: the issue address wraps modulo 2^ADDR_W. The base is always 16-byte aligned, so no intra-line wrap occurs.
- Simultaneous dc_miss and ic_miss: D is served first. I is granted in the IDLE cycle after D's DONE.
- busy = (state != IDLE).

Decomposition:
- Shared package: state encoding enum (IDLE/WRITE/FILL/DONE), owner encoding (OWN_I/OWN_D), LINE_MASK = 16'hFFF0.
- One natural sub-module, fill_counter: a WORDS-range counter with clear/inc/last outputs, instantiated twice (issue_cnt, recv_cnt).

Test Plan:
- Single I-miss: ic_miss_addr=0x1236, memory preloaded with word value = address.
  - Reads issued to 0x1230..0x123E on consecutive cycles.
  - ic_fill_word 0..7 with data 0x1230..0x123E, first word 4 cycles after the first issue.
  - ic_fill_done with word 7; total 12 cycles; no dc_fill_valid.
- Concurrent dc_miss=0x0040 and ic_miss=0x0400 in the same cycle:
  - D fill completes fully first.
  - I is granted after DONE plus one IDLE cycle.
  - Both dones pulse exactly once.
- dc_wr_req (0x00A0, 0xBEEF) raised together with ic_miss:
  - The write goes first: one cycle of mem_wr=1, addr 0xA0, data 0xBEEF, dc_wr_ack=1.
  - The I fill follows.
- rst asserted at receive of word 3 of a fill:
  - All outputs are 0 next cycle, busy=0.
  - The remaining 4 stale mem_data_valid pulses produce no fill_valid.
- Spurious mem_data_valid in IDLE, and ic_miss deasserted at word 2:
  - The spurious pulse is ignored.
  - The fill still delivers words 3..7 and the done pulse.
- Address wrap: dc_miss_addr=0xFFFA → reads 0xFFF0..0xFFFE, words 0..7 returned in order.
